store_rmw_ctrl: RTL and testbench
=================================

Name: store_rmw_ctrl

Overview:
Sequences data-memory accesses for the MIPS datapath: loads, full-word stores and byte/halfword stores.
Sub-word stores run as a read-modify-write: read the word, merge the new byte/halfword into it, write it back.
Sits between the MEM stage and the synchronous data RAM; stalls the pipeline while busy.
Accepts one request at a time.

Parameters:
MEM_LAT, 1, RAM read latency in cycles from the read-enable cycle to valid mem_rdata; legal 1..4.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  MEM stage access request
req_ready  out  1  controller idle, request accepted this cycle if req_valid
req_we  in  1  1=store, 0=load
req_lsb  in  1  byte store
req_lsh  in  1  halfword store
req_addr  in  32  byte address
req_wdata  in  32  store data (byte/half right-justified)
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  raw word read (loads only; else 0)
resp_err  out  1  misaligned access flag, valid with resp_valid
stall  out  1  = ~req_ready | (req_valid & req_ready)
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  32  word address {addr[31:2],2'b00}
mem_wdata  out  32  RAM write data
mem_rdata  in  32  RAM read data

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- States: IDLE, READ, WAIT, WRITE, DONE. Memory and response outputs are decoded from the state and the captured registers.
- Accept: req_valid & req_ready (ready only in IDLE). On accept, capture addr, wdata, we, lsb, lsh.
- Size decode:
  - {lsb,lsh}=10: byte.
  - 01: halfword.
  - 00 or 11: word (11 is treated as word).
- Transitions out of IDLE on accept:
  - word store -> WRITE
  - load or sub-word store -> READ
- READ: mem_en=1, mem_we=0 for exactly one cycle -> WAIT.
- WAIT: lasts MEM_LAT cycles, counted by a 2-bit down-counter. On the last WAIT cycle, latch mem_rdata into rd_word.
  - Load -> DONE.
  - Sub-word store -> WRITE.
- WRITE: mem_en=1, mem_we=1 -> DONE.
  - Word store: mem_wdata = captured wdata.
  - Sub-word store: mem_wdata = merge(rd_word, wdata, addr[1:0]).
- Merge rules:
  - Halfword: addr[1]=1 gives {din[15:0], mem[15:0]}; addr[1]=0 gives {mem[31:16], din[15:0]}. addr[0] is ignored.
  - Byte: din[7:0] replaces byte lane addr[1:0] (lane 0 = bits 7:0).
- DONE: resp_valid=1 for one cycle -> IDLE. resp_rdata = rd_word for loads, 0 otherwise.
- Latency from the accept edge, with MEM_LAT=1:
  - word store: WRITE in cycle 1, DONE in cycle 2
  - load: DONE in cycle 3
  - sub-word store: WRITE in cycle 3, DONE in cycle 4
  - Each extra MEM_LAT cycle adds one cycle to the load and sub-word store paths.
- Back-to-back: a new request can be accepted in the IDLE cycle after DONE. There is no overlap between requests.
- Reset mid-operation: state goes to IDLE at the reset edge. A partially read RMW is abandoned and no write is issued.
- Reset values: req_ready=0 while rst is sampled high, 1 thereafter. All other outputs are 0; counter and rd_word cleared.
- req_valid deasserted in IDLE: stay IDLE, with no memory activity.

Optional Feature:
STORE_MISALIGN_CHECK_EN
- Defined: misaligned requests go IDLE->DONE with resp_err=1 and no mem_en pulse. Misaligned means halfword with addr[0]=1, or word (load or store) with addr[1:0]!=0.
- Undefined: resp_err is tied 0 and low address bits are ignored per the merge rules.

Decomposition:
- Package store_rmw_pkg holds:
  - the state encoding, a 3-bit localparam set: IDLE, READ, WAIT, WRITE, DONE
  - size codes SZ_WORD/SZ_HALF/SZ_BYTE
- The merge is the existing combinational storebh module, instantiated once with din = captured wdata, memin = rd_word, offset = addr[1:0] and lsb/lsh = the captured flags.
- The FSM and counter stay in store_rmw_ctrl.

Test Plan:
1. Reset held 3 cycles mid-RMW (during WAIT) -> no mem_we pulse. Next cycle: IDLE, req_ready=1, all other outputs 0.
2. sw addr 0x100, data 0xDEADBEEF -> mem_we in cycle 1, mem_addr=0x100, mem_wdata=0xDEADBEEF, resp_valid in cycle 2.
3. sb addr 0x102, data 0xAA, RAM word 0x11223344 -> read in cycle 1; write in cycle 3 with 0x11AA3344; resp_valid in cycle 4 (MEM_LAT=1).
4. sh addr 0x102, data 0xBEEF, RAM word 0x11223344 -> write 0xBEEF3344. Same with addr 0x100 -> write 0x1122BEEF.
5. lw addr 0x104 with MEM_LAT=3 -> mem_en in cycle 1; resp_valid in cycle 5 with resp_rdata = RAM word; stall high cycles 0-5 of the request.
6. With STORE_MISALIGN_CHECK_EN: sh addr 0x101 -> no mem_en, resp_valid and resp_err in cycle 1. Without it: sh addr 0x101 -> write lane bits 15:0.

Source files
------------

// File: rtl/store_rmw_pkg.sv
// Shared types for the store read-modify-write controller: FSM state encoding,
// access size codes and the {lsb,lsh} size decode.
package store_rmw_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2
    } size_t;

    // {lsb,lsh} = 11 is deliberately treated as a word access.
    function automatic size_t decode_size(input logic lsb, input logic lsh);
        case ({lsb, lsh})
            2'b10:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/store_rmw_ctrl_if.sv
// MEM-stage request/response and data-RAM bus bundle for store_rmw_ctrl.
// slave = controller view, master = pipeline/RAM side.
interface store_rmw_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_lsb;
    logic        req_lsh;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stall;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_lsb, req_lsh, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, stall,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_lsb, req_lsh, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, stall,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/store_rmw_ctrl_storebh.sv
// storebh: combinational byte/halfword merge of store data into a word read
// from memory. Word-sized accesses pass din straight through.
module storebh
    import store_rmw_pkg::*;
(
    input  logic [31:0] din,
    input  logic [31:0] memin,
    input  logic [1:0]  offset,
    input  logic        lsb,
    input  logic        lsh,
    output logic [31:0] dout
);
    always_comb begin
        // NOTE: dout gets a full default first so every path assigns it and no latch is inferred.
        dout = memin;
        case (decode_size(lsb, lsh))
            SZ_BYTE: begin
                case (offset)
                    2'd0:    dout[7:0]   = din[7:0];
                    2'd1:    dout[15:8]  = din[7:0];
                    2'd2:    dout[23:16] = din[7:0];
                    default: dout[31:24] = din[7:0];
                endcase
            end
            SZ_HALF: begin
                // offset[0] is ignored: the halfword lands on the lane picked by offset[1].
                if (offset[1]) dout[31:16] = din[15:0];
                else           dout[15:0]  = din[15:0];
            end
            default: dout = din;
        endcase
    end
endmodule

// File: rtl/store_rmw_ctrl.sv
// Data-memory access sequencer: loads, word stores and read-modify-write sub-word stores.
// Optional misaligned-access trap enabled by `define STORE_MISALIGN_CHECK_EN.
module store_rmw_ctrl
    import store_rmw_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input logic             clk,
    input logic             rst,
    store_rmw_ctrl_if.slave bus
);
    localparam logic [1:0] WAIT_LOAD = 2'(MEM_LAT - 1);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rd_word_q, rd_word_d;
    logic        we_q, we_d;
    logic        lsb_q, lsb_d;
    logic        lsh_q, lsh_d;
    logic        err_q, err_d;

    size_t       req_size;
    logic        misalign;
    logic [31:0] merged;

    assign req_size = decode_size(bus.req_lsb, bus.req_lsh);

`ifdef STORE_MISALIGN_CHECK_EN
    assign misalign = ((req_size == SZ_HALF) && bus.req_addr[0]) ||
                      ((req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    storebh u_storebh (
        .din    (wdata_q),
        .memin  (rd_word_q),
        .offset (addr_q[1:0]),
        .lsb    (lsb_q),
        .lsh    (lsh_q),
        .dout   (merged)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_word_d = rd_word_q;
        we_d      = we_q;
        lsb_d     = lsb_q;
        lsh_d     = lsh_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    we_d    = bus.req_we;
                    lsb_d   = bus.req_lsb;
                    lsh_d   = bus.req_lsh;
                    err_d   = misalign;
                    if (misalign)                              state_d = DONE;
                    else if (bus.req_we && req_size == SZ_WORD) state_d = WRITE;
                    else                                       state_d = READ;
                end
            end
            READ: begin
                state_d = WAIT;
                cnt_d   = WAIT_LOAD;
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    rd_word_d = bus.mem_rdata;
                    state_d   = we_q ? WRITE : DONE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: datapath registers are cleared too, so every output reads 0 straight after reset.
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_word_q <= '0;
            we_q      <= 1'b0;
            lsb_q     <= 1'b0;
            lsh_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge _d values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_word_q <= rd_word_d;
            we_q      <= we_d;
            lsb_q     <= lsb_d;
            lsh_q     <= lsh_d;
            err_q     <= err_d;
        end
    end

    logic        ready;
    logic        mem_en;
    logic        mem_we;
    logic        resp_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] resp_rdata;

    always_comb begin
        ready      = (state_q == IDLE) && !rst;
        mem_en     = (state_q == READ) || (state_q == WRITE);
        mem_we     = (state_q == WRITE);
        resp_valid = (state_q == DONE);
        mem_addr   = mem_en ? {addr_q[31:2], 2'b00} : 32'h0;
        mem_wdata  = mem_we ? merged : 32'h0;
        resp_rdata = (resp_valid && !we_q && !err_q) ? rd_word_q : 32'h0;
    end

    assign bus.req_ready  = ready;
    assign bus.stall      = !ready || (bus.req_valid && ready);
    assign bus.mem_en     = mem_en;
    assign bus.mem_we     = mem_we;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = mem_wdata;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_rdata = resp_rdata;
    assign bus.resp_err   = resp_valid && err_q;
endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Bench for store_rmw_ctrl: two instances (MEM_LAT 1 and 3) against a
// transaction-level reference model and a latency-accurate RAM model.
module tb_store_rmw_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    store_rmw_ctrl_if bus0();
    store_rmw_ctrl_if bus1();

    store_rmw_ctrl #(.MEM_LAT(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    store_rmw_ctrl #(.MEM_LAT(3)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    logic        d_valid [2];
    logic        d_we    [2];
    logic        d_lsb   [2];
    logic        d_lsh   [2];
    logic [31:0] d_addr  [2];
    logic [31:0] d_wdata [2];
    logic [31:0] r_data  [2];

    logic        o_ready [2];
    logic        o_stall [2];
    logic        o_men   [2];
    logic        o_mwe   [2];
    logic        o_rv    [2];
    logic        o_err   [2];
    logic [31:0] o_maddr [2];
    logic [31:0] o_mwdata[2];
    logic [31:0] o_rdata [2];

    assign bus0.req_valid = d_valid[0];  assign bus1.req_valid = d_valid[1];
    assign bus0.req_we    = d_we[0];     assign bus1.req_we    = d_we[1];
    assign bus0.req_lsb   = d_lsb[0];    assign bus1.req_lsb   = d_lsb[1];
    assign bus0.req_lsh   = d_lsh[0];    assign bus1.req_lsh   = d_lsh[1];
    assign bus0.req_addr  = d_addr[0];   assign bus1.req_addr  = d_addr[1];
    assign bus0.req_wdata = d_wdata[0];  assign bus1.req_wdata = d_wdata[1];
    assign bus0.mem_rdata = r_data[0];   assign bus1.mem_rdata = r_data[1];

    assign o_ready[0]  = bus0.req_ready;  assign o_ready[1]  = bus1.req_ready;
    assign o_stall[0]  = bus0.stall;      assign o_stall[1]  = bus1.stall;
    assign o_men[0]    = bus0.mem_en;     assign o_men[1]    = bus1.mem_en;
    assign o_mwe[0]    = bus0.mem_we;     assign o_mwe[1]    = bus1.mem_we;
    assign o_rv[0]     = bus0.resp_valid; assign o_rv[1]     = bus1.resp_valid;
    assign o_err[0]    = bus0.resp_err;   assign o_err[1]    = bus1.resp_err;
    assign o_maddr[0]  = bus0.mem_addr;   assign o_maddr[1]  = bus1.mem_addr;
    assign o_mwdata[0] = bus0.mem_wdata;  assign o_mwdata[1] = bus1.mem_wdata;
    assign o_rdata[0]  = bus0.resp_rdata; assign o_rdata[1]  = bus1.resp_rdata;

    // RAM model: one 256-word array per instance, read data valid only MEM_LAT cycles after the read-enable cycle.
    logic [31:0] ram  [2][256];
    logic [3:0]  pv   [2];
    logic [7:0]  pidx [2][4];
    logic        bd_we = 1'b0;
    logic [7:0]  bd_idx = '0;
    logic [31:0] bd_data = '0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (bd_we) ram[i][bd_idx] <= bd_data;
            else if (o_men[i] && o_mwe[i]) ram[i][o_maddr[i][9:2]] <= o_mwdata[i];
            if (rst) pv[i] <= '0;
            else     pv[i] <= {pv[i][2:0], o_men[i] & ~o_mwe[i]};
            for (int s = 3; s > 0; s--) pidx[i][s] <= pidx[i][s-1];
            pidx[i][0] <= o_maddr[i][9:2];
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            r_data[i] = 32'hA5A5_5A5A;
            if (pv[i][lat(i)-1]) r_data[i] = ram[i][pidx[i][lat(i)-1]];
        end
    end

    // Reference memory: what each RAM should hold after every completed request.
    logic [31:0] ref_mem [2][256];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic poke(input int idx, input logic [31:0] val);
        bd_we   = 1'b1;
        bd_idx  = idx[7:0];
        bd_data = val;
        ref_mem[0][idx] = val;
        ref_mem[1][idx] = val;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic check_idle_outputs(input int i, input string tag);
        check({tag, ".ready"},  32'(o_ready[i]), 32'd1);
        check({tag, ".stall"},  32'(o_stall[i]), 32'd0);
        check({tag, ".mem_en"}, 32'(o_men[i]),   32'd0);
        check({tag, ".mem_we"}, 32'(o_mwe[i]),   32'd0);
        check({tag, ".maddr"},  o_maddr[i],      32'd0);
        check({tag, ".mwdata"}, o_mwdata[i],     32'd0);
        check({tag, ".rvalid"}, 32'(o_rv[i]),    32'd0);
        check({tag, ".rdata"},  o_rdata[i],      32'd0);
        check({tag, ".err"},    32'(o_err[i]),   32'd0);
    endtask

    // Starts and ends on a negedge with the instance idle; fl = {lsb,lsh}.
    task automatic run_txn(input int i, input logic we, input logic [1:0] fl,
                           input logic [31:0] addr, input logic [31:0] wd, input string tag);
        int L, sz, sh;
        bit mis;
        logic [7:0]  idx;
        logic [31:0] old, exp_wd, exp_rd;
        int e_rd, e_wr, e_rcyc, e_wcyc, e_resp;
        logic e_err;
        int n_rd, n_wr, o_rcyc, o_wcyc, o_resp, stall_cnt;
        logic [31:0] o_ra, o_wa, o_wd, o_rd;
        logic o_e;

        L   = lat(i);
        sz  = (fl == 2'b10) ? 2 : (fl == 2'b01) ? 1 : 0;
        mis = 1'b0;
`ifdef STORE_MISALIGN_CHECK_EN
        mis = (sz == 1 && addr[0]) || (sz == 0 && addr[1:0] != 2'b00);
`endif
        idx = addr[9:2];
        old = ref_mem[i][idx];
        e_rd = 0; e_wr = 0; e_rcyc = 0; e_wcyc = 0; e_resp = 0;
        exp_wd = '0; exp_rd = '0; e_err = 1'b0;
        if (mis) begin
            e_resp = 1; e_err = 1'b1;
        end else if (we && sz == 0) begin
            e_wr = 1; e_wcyc = 1; e_resp = 2; exp_wd = wd;
        end else if (!we) begin
            e_rd = 1; e_rcyc = 1; e_resp = 2 + L; exp_rd = old;
        end else begin
            e_rd = 1; e_rcyc = 1; e_wr = 1; e_wcyc = 2 + L; e_resp = 3 + L;
            if (sz == 1) begin
                sh = addr[1] ? 16 : 0;
                exp_wd = (old & ~(32'h0000_FFFF << sh)) | ({16'h0, wd[15:0]} << sh);
            end else begin
                sh = int'(addr[1:0]) * 8;
                exp_wd = (old & ~(32'h0000_00FF << sh)) | ({24'h0, wd[7:0]} << sh);
            end
        end
        if (e_wr != 0) ref_mem[i][idx] = exp_wd;

        d_we[i] = we; d_lsb[i] = fl[1]; d_lsh[i] = fl[0];
        d_addr[i] = addr; d_wdata[i] = wd; d_valid[i] = 1'b1;
        #1;
        check({tag, ".ready0"}, 32'(o_ready[i]), 32'd1);
        stall_cnt = o_stall[i] ? 1 : 0;
        n_rd = 0; n_wr = 0; o_rcyc = 0; o_wcyc = 0; o_resp = -1;
        o_ra = '0; o_wa = '0; o_wd = '0; o_rd = '0; o_e = 1'b0;
        @(posedge clk);
        #1 d_valid[i] = 1'b0;
        for (int c = 1; c <= 30 && o_resp < 0; c++) begin
            @(negedge clk);
            if (o_men[i]) begin
                if (o_mwe[i]) begin
                    n_wr++; o_wcyc = c; o_wa = o_maddr[i]; o_wd = o_mwdata[i];
                end else begin
                    n_rd++; o_rcyc = c; o_ra = o_maddr[i];
                end
            end
            if (o_stall[i]) stall_cnt++;
            if (o_rv[i]) begin
                o_resp = c; o_rd = o_rdata[i]; o_e = o_err[i];
            end
        end
        if (o_resp < 0) begin
            check({tag, ".timeout"}, 32'd0, 32'd1);
            return;
        end
        check({tag, ".n_rd"}, 32'(n_rd), 32'(e_rd));
        if (e_rd != 0) begin
            check({tag, ".rd_cyc"},  32'(o_rcyc), 32'(e_rcyc));
            check({tag, ".rd_addr"}, o_ra, {addr[31:2], 2'b00});
        end
        check({tag, ".n_wr"}, 32'(n_wr), 32'(e_wr));
        if (e_wr != 0) begin
            check({tag, ".wr_cyc"},  32'(o_wcyc), 32'(e_wcyc));
            check({tag, ".wr_addr"}, o_wa, {addr[31:2], 2'b00});
            check({tag, ".wr_data"}, o_wd, exp_wd);
        end
        check({tag, ".resp_cyc"}, 32'(o_resp), 32'(e_resp));
        check({tag, ".rdata"},    o_rd, exp_rd);
        check({tag, ".err"},      32'(o_e), 32'(e_err));
        check({tag, ".stall_n"},  32'(stall_cnt), 32'(e_resp + 1));
        @(negedge clk);
        check({tag, ".ready_after"}, 32'(o_ready[i]), 32'd1);
        check({tag, ".stall_after"}, 32'(o_stall[i]), 32'd0);
    endtask

    task automatic reset_mid_rmw();
        int we_seen;
        we_seen = 0;
        d_we[1] = 1'b1; d_lsb[1] = 1'b1; d_lsh[1] = 1'b0;
        d_addr[1] = 32'h0000_0109; d_wdata[1] = 32'h0000_0077; d_valid[1] = 1'b1;
        @(posedge clk);
        #1 d_valid[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rstmid.in_wait_we", 32'(o_mwe[1]), 32'd0);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (o_mwe[1]) we_seen++;
            if (k == 0) check("rstmid.ready_in_rst", 32'(o_ready[1]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("rstmid.no_we", 32'(we_seen), 32'd0);
        check_idle_outputs(1, "rstmid");
        check("rstmid.ram_kept", ram[1][8'h42], ref_mem[1][8'h42]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic        we;
        logic [1:0]  fl;
        logic [31:0] addr, wd;
        for (int i = 0; i < 2; i++) begin
            d_valid[i] = 1'b0; d_we[i] = 1'b0; d_lsb[i] = 1'b0; d_lsh[i] = 1'b0;
            d_addr[i] = '0; d_wdata[i] = '0;
        end

        @(negedge clk);
        check("rst.ready_in_rst", 32'(o_ready[0]), 32'd0);
        for (int w = 0; w < 256; w++) poke(w, $urandom);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs(0, "rst0");
        check_idle_outputs(1, "rst1");

        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("idle.mem_en", 32'(o_men[0] | o_men[1]), 32'd0);
        end

        reset_mid_rmw();

        run_txn(0, 1'b1, 2'b00, 32'h0000_0100, 32'hDEAD_BEEF, "sw100");
        poke(8'h40, 32'h1122_3344);
        run_txn(0, 1'b1, 2'b10, 32'h0000_0102, 32'h0000_00AA, "sb102");
        poke(8'h40, 32'h1122_3344);
        run_txn(0, 1'b1, 2'b01, 32'h0000_0102, 32'h0000_BEEF, "sh102");
        poke(8'h40, 32'h1122_3344);
        run_txn(0, 1'b1, 2'b01, 32'h0000_0100, 32'h0000_BEEF, "sh100");
        poke(8'h40, 32'h1122_3344);
        run_txn(0, 1'b1, 2'b01, 32'h0000_0101, 32'h0000_BEEF, "sh101");
        run_txn(1, 1'b0, 2'b00, 32'h0000_0104, 32'h0, "lw104_L3");
        run_txn(1, 1'b1, 2'b11, 32'h0000_0108, 32'hCAFE_F00D, "sw11_L3");

        for (int k = 0; k < 60; k++) begin
            we   = 1'($urandom_range(0, 1));
            fl   = 2'($urandom_range(0, 3));
            addr = $urandom;
            wd   = $urandom;
            run_txn(0, we, fl, addr, wd, $sformatf("rnd%0d_L1", k));
            run_txn(1, we, fl, addr, wd, $sformatf("rnd%0d_L3", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
